// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2 to dual 10-key keypad decoder with press stretching,
// OUT 2 key-select latch and registered active-low EF vector for the cdp1802.
module studio2_keypad #(
    parameter int MIN_HOLD = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic [2:0]  io_n,
    input  logic        io_out,
    input  logic [7:0]  io_dout,
    input  logic        efx,
    output logic [3:0]  ef,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_keys,
    output logic [9:0]  kp2_keys
);
    logic       primed, old_tog, ev, unused_ok;
    logic [9:0] hit1, hit2;
    logic [15:0] k1x, k2x;

    assign unused_ok = ^io_dout[7:4];
    assign ev = primed && (ps2_key[10] != old_tog) && !ps2_key[8];

    // One-hot digit decode; unmapped codes yield zero and are ignored downstream.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        case (ps2_key[7:0])
            8'h45: hit1 = 10'h001;
            8'h16: hit1 = 10'h002;
            8'h1E: hit1 = 10'h004;
            8'h26: hit1 = 10'h008;
            8'h25: hit1 = 10'h010;
            8'h2E: hit1 = 10'h020;
            8'h36: hit1 = 10'h040;
            8'h3D: hit1 = 10'h080;
            8'h3E: hit1 = 10'h100;
            8'h46: hit1 = 10'h200;
            8'h70: hit2 = 10'h001;
            8'h69: hit2 = 10'h002;
            8'h72: hit2 = 10'h004;
            8'h7A: hit2 = 10'h008;
            8'h6B: hit2 = 10'h010;
            8'h73: hit2 = 10'h020;
            8'h74: hit2 = 10'h040;
            8'h6C: hit2 = 10'h080;
            8'h75: hit2 = 10'h100;
            8'h7D: hit2 = 10'h200;
            default: ;
        endcase
    end

    for (genvar g = 0; g < 2; g++) begin : pad
        logic [9:0]       keys, pend, keys_d, pend_d, m;
        logic [CNT_W-1:0] cnt, cnt_d;
        logic             sat, reach;
        assign m     = ev ? (g == 0 ? hit1 : hit2) : '0;
        assign sat   = cnt == CNT_W'(MIN_HOLD);
        assign reach = cnt == CNT_W'(MIN_HOLD - 1);
        // A break arriving once the hold time is met (or being met this cycle) releases at once.
        always_comb begin
            keys_d = reach ? keys & ~pend : keys;
            pend_d = reach ? '0 : pend;
            cnt_d  = sat ? cnt : cnt + 1'b1;
            if (ps2_key[9] && m != '0) begin
                keys_d = keys_d | m;
                pend_d = pend_d & ~m;
                cnt_d  = '0;
            end else if (!ps2_key[9] && (keys & m) != '0) begin
                if (sat || reach) keys_d = keys_d & ~m;
                else pend_d = pend_d | m;
            end
        end
        always_ff @(posedge clk or negedge resetq) begin
            if (!resetq) begin
                keys <= '0;
                pend <= '0;
                cnt  <= '0;
            end else begin
                keys <= keys_d;
                pend <= pend_d;
                cnt  <= cnt_d;
            end
        end
    end

    assign kp1_keys = pad[0].keys;
    assign kp2_keys = pad[1].keys;
    assign k1x = {6'b0, kp1_keys};
    assign k2x = {6'b0, kp2_keys};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            primed  <= 1'b0;
            old_tog <= 1'b0;
            key_sel <= 4'h0;
            ef      <= 4'b1111;
        end else begin
            primed  <= 1'b1;
            old_tog <= ps2_key[10];
            key_sel <= (io_out && io_n == 3'd2) ? io_dout[3:0] : key_sel;
            ef      <= {~k2x[key_sel], ~k1x[key_sel], 1'b1, efx};
        end
    end
endmodule

// File: tb/tb_studio2_keypad.sv
// tb_studio2_keypad: directed checks of decode, hold stretching, key select and EF timing.
module tb_studio2_keypad;
    logic        clk, resetq, io_out, efx;
    logic [10:0] ps2_key;
    logic [2:0]  io_n;
    logic [7:0]  io_dout;
    logic [3:0]  ef, key_sel;
    logic [9:0]  kp1_keys, kp2_keys;
    int tests = 0, fails = 0;

    studio2_keypad #(.MIN_HOLD(100), .CNT_W(7)) dut (
        .clk(clk), .resetq(resetq), .ps2_key(ps2_key), .io_n(io_n),
        .io_out(io_out), .io_dout(io_dout), .efx(efx), .ef(ef),
        .key_sel(key_sel), .kp1_keys(kp1_keys), .kp2_keys(kp2_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic mk, input logic ext, input logic [7:0] code);
        @(negedge clk);
        ps2_key = {~ps2_key[10], mk, ext, code};
        @(posedge clk);
    endtask

    task automatic out_cmd(input logic [2:0] n, input logic [7:0] d);
        @(negedge clk);
        io_n = n; io_dout = d; io_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io_out = 1'b0;
    endtask

    initial begin
        resetq = 1'b0; ps2_key = 11'h400; io_n = '0; io_out = 1'b0; io_dout = '0; efx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) resetq = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ef", 16'(ef), 16'hF);
        chk("rst_sel", 16'(key_sel), 16'h0);
        chk("rst_kp1", 16'(kp1_keys), 16'h000);
        chk("rst_kp2", 16'(kp2_keys), 16'h000);

        send(1, 0, 8'h1E);
        @(negedge clk);
        chk("make_1e", 16'(kp1_keys), 16'h004);
        out_cmd(3'd2, 8'h02);
        chk("sel_2", 16'(key_sel), 16'h2);
        @(posedge clk); @(negedge clk);
        chk("ef_sel2", 16'(ef), 16'b1011);
        out_cmd(3'd3, 8'h05);
        chk("sel_n3", 16'(key_sel), 16'h2);

        send(0, 0, 8'h1E);
        repeat (110) @(posedge clk);
        @(negedge clk);
        chk("brk_1e", 16'(kp1_keys), 16'h000);
        chk("ef_idle", 16'(ef), 16'hF);

        send(1, 0, 8'h72);
        repeat (9) @(posedge clk);
        send(0, 0, 8'h72);
        @(negedge clk);
        chk("pend_held", 16'(kp2_keys), 16'h004);
        repeat (89) @(posedge clk);
        @(negedge clk);
        chk("hold99_kp2", 16'(kp2_keys), 16'h004);
        chk("hold99_ef", 16'(ef), 16'b0111);
        @(posedge clk); @(negedge clk);
        chk("hold100_kp2", 16'(kp2_keys), 16'h000);
        chk("hold100_ef", 16'(ef), 16'b0111);
        @(posedge clk); @(negedge clk);
        chk("hold101_ef", 16'(ef), 16'b1111);

        send(1, 0, 8'h16);
        send(1, 0, 8'h7D);
        out_cmd(3'd2, 8'h01);
        @(posedge clk); @(negedge clk);
        chk("ef_sel1", 16'(ef), 16'b1011);
        out_cmd(3'd2, 8'h09);
        @(posedge clk); @(negedge clk);
        chk("ef_sel9", 16'(ef), 16'b0111);
        out_cmd(3'd2, 8'h0A);
        @(posedge clk); @(negedge clk);
        chk("ef_selA", 16'(ef), 16'b1111);
        chk("multi_kp1", 16'(kp1_keys), 16'h002);
        chk("multi_kp2", 16'(kp2_keys), 16'h200);

        send(1, 1, 8'h70);
        send(1, 0, 8'h1C);
        send(0, 1, 8'h7D);
        @(negedge clk);
        chk("ign_kp1", 16'(kp1_keys), 16'h002);
        chk("ign_kp2", 16'(kp2_keys), 16'h200);
        efx = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ef_efx", 16'(ef), 16'b1110);

        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h45};
        io_n = 3'd2; io_dout = 8'h00; io_out = 1'b1;
        @(posedge clk); @(negedge clk);
        io_out = 1'b0;
        chk("sim_sel", 16'(key_sel), 16'h0);
        chk("sim_kp1", 16'(kp1_keys), 16'h003);
        @(posedge clk); @(negedge clk);
        chk("sim_ef", 16'(ef), 16'b1010);

        repeat (110) @(posedge clk);
        send(0, 0, 8'h16);
        @(negedge clk);
        chk("sat_brk", 16'(kp1_keys), 16'h001);
        send(0, 0, 8'h26);
        @(negedge clk);
        chk("brk_unheld", 16'(kp1_keys), 16'h001);

        efx = 1'b1;
        send(1, 0, 8'h26);
        send(0, 0, 8'h26);
        @(negedge clk);
        chk("pre_rst_kp1", 16'(kp1_keys), 16'h009);
        #1 resetq = 1'b0;
        #1;
        chk("arst_ef", 16'(ef), 16'hF);
        chk("arst_sel", 16'(key_sel), 16'h0);
        chk("arst_kp1", 16'(kp1_keys), 16'h000);
        chk("arst_kp2", 16'(kp2_keys), 16'h000);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h3D};
        repeat (2) @(posedge clk);
        @(negedge clk) resetq = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("noprime", 16'(kp1_keys), 16'h000);
        send(1, 0, 8'h3D);
        @(negedge clk);
        chk("reprime", 16'(kp1_keys), 16'h080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
